// File: rtl/alu_result_serializer_pkg.sv
// Shared FSM encoding, header byte and counter sizing for the
// ALU result serializer.
package alu_ser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } ser_state_e;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_result_serializer_valid_edge_detect.sv
// Registered rising-edge detector; usable for any ALU status flag.
module valid_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/alu_result_serializer.sv
// Streams ALU results to the UART TX as bytes, LSB first, with a
// one-entry holding buffer. ALU_SER_HEADER_EN prefixes 8'hA5 per result.
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  TX_BUSY,
    input  logic                  CLR_OVR,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VALID,
    output logic                  SER_BUSY,
    output logic                  OVERRUN
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
`ifdef ALU_SER_HEADER_EN
    localparam int LAST = NUM_BYTES;
`else
    localparam int LAST = NUM_BYTES - 1;
`endif
    localparam int CW = cnt_width(LAST + 1);

    ser_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic full_q, full_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] txd_q, txd_d;
    logic txv_q, txv_d;
    logic busy_q, busy_d;
    logic ovr_q, ovr_d;
    logic cap, last, drain;
    logic [7:0] byte_sel;

    valid_edge_detect u_vld (
        .CLK   (CLK),
        .RST   (RST),
        .sig_i (OUT_VALID),
        .rise_o(cap)
    );

    assign last  = (cnt_q == CW'(LAST));
    assign drain = (state_q == WAIT_LO) && !TX_BUSY && last;

    always_comb begin
        byte_sel = 8'h00;
`ifdef ALU_SER_HEADER_EN
        if (cnt_q == '0) byte_sel = HDR_BYTE;
        for (int i = 0; i < NUM_BYTES; i++)
            if (cnt_q == CW'(i + 1)) byte_sel = cur_q[8*i +: 8];
`else
        for (int i = 0; i < NUM_BYTES; i++)
            if (cnt_q == CW'(i)) byte_sel = cur_q[8*i +: 8];
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cap) state_d = SEND;
            SEND:    if (!TX_BUSY) state_d = WAIT_HI;
            WAIT_HI: if (TX_BUSY) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (!last || full_q || cap) state_d = SEND;
                    else                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d  = cur_q;
        buf_d  = buf_q;
        full_d = full_q;
        cnt_d  = cnt_q;
        txd_d  = txd_q;
        txv_d  = 1'b0;
        ovr_d  = ovr_q & ~CLR_OVR;
        unique case (state_q)
            SEND: begin
                if (!TX_BUSY) begin
                    txd_d = byte_sel;
                    txv_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (!last) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (full_q) begin
                        cur_d  = buf_q;
                        buf_d  = '0;
                        full_d = 1'b0;
                        cnt_d  = '0;
                    end
                end
            end
            default: ;
        endcase
        // A capture on the final drain edge behaves as if already idle.
        if (cap) begin
            if (state_q == IDLE || (drain && !full_q)) begin
                cur_d = ALU_OUT;
                cnt_d = '0;
            end else if (!full_d) begin
                buf_d  = ALU_OUT;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE) | full_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_q  <= '0;
            buf_q  <= '0;
            full_q <= 1'b0;
            cnt_q  <= '0;
            txd_q  <= 8'h00;
            txv_q  <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            buf_q  <= buf_d;
            full_q <= full_d;
            cnt_q  <= cnt_d;
            txd_q  <= txd_d;
            txv_q  <= txv_d;
            busy_q <= busy_d;
            ovr_q  <= ovr_d;
        end
    end

    assign TX_P_DATA  = txd_q;
    assign TX_D_VALID = txv_q;
    assign SER_BUSY   = busy_q;
    assign OVERRUN    = ovr_q;

endmodule
